axi_llc_r_master_cwf: RTL and testbench

Successor refill-R unit of the LLC eviction/refill path. It sits between the refill descriptor stream and the data-way request arbiter.
- Queues up to DescDepth descriptors in order, so multiple refills can be outstanding on the AXI master port.
- Writes refill R beats to the data ways in critical-word-first (wrapping) order when enabled.
- Tracks SLVERR/DECERR responses per refill.
- Forwards each descriptor, with its error flag, to the next unit only after its line is complete.

---
 rtl/axi_llc_pkg.sv | 58 +++++
 rtl/axi_llc_r_master_cwf_fifo.sv | 50 +++++
 rtl/axi_llc_r_master_cwf.sv | 134 +++++++++++++
 tb/tb_axi_llc_r_master_cwf.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_llc_pkg.sv
// Shared LLC types for the refill-R path: static configuration, descriptor,
// data-way request and AXI R payload.
package axi_llc_pkg;

    localparam int unsigned AddrWidth      = 32;
    localparam int unsigned DataWidth      = 32;
    localparam int unsigned NumWays        = 4;
    localparam int unsigned LineAddrWidth  = 16;
    localparam int unsigned BlkOffsetWidth = 8;

    typedef struct packed {
        int unsigned NumBlocks;
        int unsigned BlockOffsetLength;
        int unsigned ByteOffsetLength;
        int unsigned IndexLength;
    } llc_cfg_t;

    typedef struct packed {
        int unsigned AddrWidthFull;
        int unsigned DataWidthFull;
    } llc_axi_cfg_t;

    localparam llc_cfg_t DefaultCfg = '{
        NumBlocks: 32'd4, BlockOffsetLength: 32'd2, ByteOffsetLength: 32'd2, IndexLength: 32'd6
    };
    localparam llc_axi_cfg_t DefaultAxiCfg = '{AddrWidthFull: AddrWidth, DataWidthFull: DataWidth};

    typedef enum logic [1:0] {
        WChanUnit = 2'd0,
        RChanUnit = 2'd1,
        EvictUnit = 2'd2,
        RefilUnit = 2'd3
    } cache_unit_e;

    typedef struct packed {
        logic [AddrWidth-1:0] a_x_addr;
        logic [NumWays-1:0]   way_ind;
        logic [3:0]           index_partition;
        logic                 refill;
    } desc_t;

    typedef struct packed {
        cache_unit_e               cache_unit;
        logic [NumWays-1:0]        way_ind;
        logic [LineAddrWidth-1:0]  line_addr;
        logic [BlkOffsetWidth-1:0] blk_offset;
        logic                      we;
        logic [DataWidth-1:0]      data;
        logic [DataWidth/8-1:0]    strb;
    } way_inp_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } r_chan_t;

endpackage

// File: rtl/axi_llc_r_master_cwf_fifo.sv
// In-order descriptor queue, non-fall-through: a pushed entry is visible at
// the head one cycle later. A push while full is dropped even if a pop occurs.
module axi_llc_r_master_cwf_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  dtype data_i,
    input  logic push_i,
    output logic full_o,
    output dtype data_o,
    input  logic pop_i,
    output logic empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    dtype            mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            push_ok, pop_ok;

    always_comb begin
        full_o  = (cnt_q == CntW'(DEPTH));
        empty_o = (cnt_q == '0);
        push_ok = push_i && !full_o;
        pop_ok  = pop_i && !empty_o;
        data_o  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
            else if (!push_ok && pop_ok) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/axi_llc_r_master_cwf.sv
// Refill-R unit: queues descriptors in order, writes refill beats to the data
// ways in critical-word-first order and forwards each descriptor with its error flag.
module axi_llc_r_master_cwf
    import axi_llc_pkg::*;
#(
    parameter llc_cfg_t     Cfg        = DefaultCfg,
    parameter llc_axi_cfg_t AxiCfg     = DefaultAxiCfg,
    parameter type          desc_t     = axi_llc_pkg::desc_t,
    parameter type          way_inp_t  = axi_llc_pkg::way_inp_t,
    parameter type          r_chan_t   = axi_llc_pkg::r_chan_t,
    parameter int unsigned  DescDepth  = 4,
    parameter bit           WrapRefill = 1'b1
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  desc_t    desc_i,
    input  logic     desc_valid_i,
    output logic     desc_ready_o,
    output desc_t    desc_o,
    output logic     desc_err_o,
    output logic     desc_valid_o,
    input  logic     desc_ready_i,
    input  r_chan_t  r_chan_mst_i,
    input  logic     r_chan_valid_i,
    output logic     r_chan_ready_o,
    output way_inp_t way_inp_o,
    output logic     way_inp_valid_o,
    input  logic     way_inp_ready_i,
    output logic     busy_o
);

    localparam int unsigned OffW    = Cfg.BlockOffsetLength;
    localparam int unsigned IdxBase = Cfg.ByteOffsetLength + Cfg.BlockOffsetLength;
    localparam int unsigned unused_axi_dw = AxiCfg.DataWidthFull;

    typedef logic [OffW-1:0] offset_t;

    desc_t   head, out_q;
    logic    fifo_full, fifo_empty, push, pop;
    logic    out_valid_q, out_err_q;
    offset_t cnt_q, beats_q, start_off, cur_off, cur_beats;
    logic    cnt_valid_q, err_q, cur_err, beat_err;
    logic    free, head_refill, beat_hs;
    logic    unused_bits;

    axi_llc_r_master_cwf_fifo #(
        .DEPTH (DescDepth),
        .dtype (desc_t)
    ) i_desc_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .data_i  (desc_i),
        .push_i  (push),
        .full_o  (fifo_full),
        .data_o  (head),
        .pop_i   (pop),
        .empty_o (fifo_empty)
    );

    // Counter values are used combinationally until the register has been
    // loaded for the current head; this makes the first beat of a refill
    // (including one directly following another refill) use its start offset.
    always_comb begin
        desc_ready_o = rst_ni && !fifo_full;
        push         = desc_valid_i && desc_ready_o;
        free         = !out_valid_q || desc_ready_i;
        head_refill  = !fifo_empty && head.refill;
        start_off    = WrapRefill ? head.a_x_addr[Cfg.ByteOffsetLength +: OffW] : '0;
        cur_off      = cnt_valid_q ? cnt_q : start_off;
        cur_beats    = cnt_valid_q ? beats_q : '0;
        cur_err      = cnt_valid_q && err_q;
        beat_err     = cur_err | r_chan_mst_i.resp[1];

        way_inp_valid_o = head_refill && r_chan_valid_i && free;
        r_chan_ready_o  = head_refill && way_inp_ready_i && free;
        beat_hs         = head_refill && r_chan_valid_i && way_inp_ready_i && free;
        pop             = !fifo_empty && free && (!head.refill || (beat_hs && r_chan_mst_i.last));

        way_inp_o            = '0;
        way_inp_o.cache_unit = RefilUnit;
        way_inp_o.we         = 1'b1;
        way_inp_o.strb       = '1;
        way_inp_o.data       = r_chan_mst_i.data;
        way_inp_o.way_ind    = head.way_ind;
        way_inp_o.line_addr[Cfg.IndexLength-1:0] = head.a_x_addr[IdxBase +: Cfg.IndexLength];
        way_inp_o.blk_offset[OffW-1:0]           = cur_off;

        desc_o       = out_q;
        desc_err_o   = out_err_q;
        desc_valid_o = out_valid_q;
        busy_o       = !fifo_empty || out_valid_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            beats_q     <= '0;
            cnt_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (beat_hs) begin
            cnt_q       <= offset_t'(cur_off + 1'b1);
            beats_q     <= offset_t'(cur_beats + 1'b1);
            err_q       <= beat_err;
            cnt_valid_q <= !r_chan_mst_i.last;
        end else if (head_refill && !cnt_valid_q) begin
            cnt_q       <= start_off;
            beats_q     <= '0;
            err_q       <= 1'b0;
            cnt_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else if (pop) begin
            out_q       <= head;
            out_valid_q <= 1'b1;
            out_err_q   <= head.refill && beat_err;
        end else if (desc_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign unused_bits = ^{head.index_partition, head.a_x_addr, r_chan_mst_i.resp[0]};

    last_beat_count: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (beat_hs && r_chan_mst_i.last) |-> (cur_beats == offset_t'(Cfg.NumBlocks - 1))
    );

endmodule

// File: tb/tb_axi_llc_r_master_cwf.sv
// Directed bench for axi_llc_r_master_cwf: a wrapping and a non-wrapping
// instance share stimulus; a cycle table plus hand sequences check them.
module tb_axi_llc_r_master_cwf;
    import axi_llc_pkg::*;

    localparam llc_cfg_t TbCfg = '{
        NumBlocks: 32'd4, BlockOffsetLength: 32'd2, ByteOffsetLength: 32'd2, IndexLength: 32'd6
    };

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    desc_t    desc_i = '0;
    logic     desc_valid_i = 1'b0;
    logic     desc_ready_i = 1'b1;
    r_chan_t  r_chan = '0;
    logic     r_valid = 1'b0;
    logic     way_ready = 1'b1;

    logic     dready [2];
    desc_t    desc_o [2];
    logic     derr [2];
    logic     dvalid [2];
    logic     rready [2];
    way_inp_t way_o [2];
    logic     wvalid [2];
    logic     busy [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    axi_llc_r_master_cwf #(
        .Cfg        (TbCfg),
        .DescDepth  (4),
        .WrapRefill (1'b1)
    ) u_wrap (
        .clk_i (clk), .rst_ni (rst_n),
        .desc_i (desc_i), .desc_valid_i (desc_valid_i), .desc_ready_o (dready[0]),
        .desc_o (desc_o[0]), .desc_err_o (derr[0]), .desc_valid_o (dvalid[0]),
        .desc_ready_i (desc_ready_i),
        .r_chan_mst_i (r_chan), .r_chan_valid_i (r_valid), .r_chan_ready_o (rready[0]),
        .way_inp_o (way_o[0]), .way_inp_valid_o (wvalid[0]), .way_inp_ready_i (way_ready),
        .busy_o (busy[0])
    );

    axi_llc_r_master_cwf #(
        .Cfg        (TbCfg),
        .DescDepth  (4),
        .WrapRefill (1'b0)
    ) u_lin (
        .clk_i (clk), .rst_ni (rst_n),
        .desc_i (desc_i), .desc_valid_i (desc_valid_i), .desc_ready_o (dready[1]),
        .desc_o (desc_o[1]), .desc_err_o (derr[1]), .desc_valid_o (dvalid[1]),
        .desc_ready_i (desc_ready_i),
        .r_chan_mst_i (r_chan), .r_chan_valid_i (r_valid), .r_chan_ready_o (rready[1]),
        .way_inp_o (way_o[1]), .way_inp_valid_o (wvalid[1]), .way_inp_ready_i (way_ready),
        .busy_o (busy[1])
    );

    typedef struct {
        logic        dv;
        desc_t       d;
        logic        rv;
        logic [31:0] rd;
        logic [1:0]  resp;
        logic        rl;
        logic        e_dready;
        logic        e_rready;
        logic        e_wvalid;
        logic [1:0]  e_blk0;
        logic [1:0]  e_blk1;
        logic [3:0]  e_wway;
        logic        e_ovalid;
        logic        e_oerr;
        logic [3:0]  e_oway;
        logic        e_busy;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic desc_t mkd(input logic refill, input logic [1:0] blk, input logic [3:0] way);
        desc_t d;
        d          = '0;
        d.refill   = refill;
        d.way_ind  = way;
        d.a_x_addr = 32'h0000_1240;
        d.a_x_addr[3:2] = blk;
        return d;
    endfunction

    function automatic vec_t mkv(input logic dv, input desc_t d, input logic rv, input logic [31:0] rd,
                                 input logic [1:0] resp, input logic rl, input logic e_dready,
                                 input logic e_rready, input logic e_wvalid, input logic [1:0] e_blk0,
                                 input logic [1:0] e_blk1, input logic [3:0] e_wway, input logic e_ovalid,
                                 input logic e_oerr, input logic [3:0] e_oway, input logic e_busy);
        vec_t v;
        v = '{dv, d, rv, rd, resp, rl, e_dready, e_rready, e_wvalid, e_blk0, e_blk1, e_wway,
              e_ovalid, e_oerr, e_oway, e_busy};
        return v;
    endfunction

    task automatic apply_vec(input vec_t v, input int idx);
        string s;
        @(negedge clk);
        desc_valid_i = v.dv;
        desc_i       = v.d;
        r_valid      = v.rv;
        r_chan.data  = v.rd;
        r_chan.resp  = v.resp;
        r_chan.last  = v.rl;
        #1;
        s = $sformatf("vec%0d", idx);
        chk({s, "_dready"}, 32'(dready[0]), 32'(v.e_dready));
        chk({s, "_rready"}, 32'(rready[0]), 32'(v.e_rready));
        chk({s, "_wvalid"}, 32'(wvalid[0]), 32'(v.e_wvalid));
        chk({s, "_ovalid"}, 32'(dvalid[0]), 32'(v.e_ovalid));
        chk({s, "_busy"}, 32'(busy[0]), 32'(v.e_busy));
        if (v.e_wvalid) begin
            chk({s, "_blk_wrap"}, 32'(way_o[0].blk_offset), 32'(v.e_blk0));
            chk({s, "_blk_lin"}, 32'(way_o[1].blk_offset), 32'(v.e_blk1));
            chk({s, "_wdata"}, way_o[0].data, v.rd);
            chk({s, "_wway"}, 32'(way_o[0].way_ind), 32'(v.e_wway));
        end
        if (v.e_ovalid) begin
            chk({s, "_oerr"}, 32'(derr[0]), 32'(v.e_oerr));
            chk({s, "_oway"}, 32'(desc_o[0].way_ind), 32'(v.e_oway));
        end
    endtask

    initial begin
        desc_t       n0, ra, rb, rc;
        logic [1:0]  starts [4];
        logic [3:0]  ways [4];
        logic [3:0]  got [3];
        logic [3:0]  exp_order [3];
        logic [1:0]  eblk;
        int          nout, beats;

        n0 = '0;
        ra = mkd(1'b1, 2'd2, 4'h1);
        rb = mkd(1'b1, 2'd1, 4'h2);
        rc = mkd(1'b1, 2'd0, 4'h4);

        //              dv  d   rv  rd         resp   rl | dr rr wv b0 b1 wway ov oe oway busy
        vecs[0]  = mkv(1, ra, 0, 32'h0,     2'b00, 0,   1, 0, 0, 0, 0, 0,   0, 0, 0,   0);
        vecs[1]  = mkv(0, n0, 1, 32'hA0,    2'b00, 0,   1, 1, 1, 2, 0, 1,   0, 0, 0,   1);
        vecs[2]  = mkv(0, n0, 1, 32'hA1,    2'b00, 0,   1, 1, 1, 3, 1, 1,   0, 0, 0,   1);
        vecs[3]  = mkv(0, n0, 1, 32'hA2,    2'b00, 0,   1, 1, 1, 0, 2, 1,   0, 0, 0,   1);
        vecs[4]  = mkv(0, n0, 1, 32'hA3,    2'b00, 1,   1, 1, 1, 1, 3, 1,   0, 0, 0,   1);
        vecs[5]  = mkv(0, n0, 0, 32'h0,     2'b00, 0,   1, 0, 0, 0, 0, 0,   1, 0, 1,   1);
        vecs[6]  = mkv(1, rb, 0, 32'h0,     2'b00, 0,   1, 0, 0, 0, 0, 0,   0, 0, 0,   0);
        vecs[7]  = mkv(1, rc, 1, 32'hB0,    2'b00, 0,   1, 1, 1, 1, 0, 2,   0, 0, 0,   1);
        vecs[8]  = mkv(0, n0, 1, 32'hB1,    2'b10, 0,   1, 1, 1, 2, 1, 2,   0, 0, 0,   1);
        vecs[9]  = mkv(0, n0, 1, 32'hB2,    2'b00, 0,   1, 1, 1, 3, 2, 2,   0, 0, 0,   1);
        vecs[10] = mkv(0, n0, 1, 32'hB3,    2'b00, 1,   1, 1, 1, 0, 3, 2,   0, 0, 0,   1);
        vecs[11] = mkv(0, n0, 1, 32'hC0,    2'b00, 0,   1, 1, 1, 0, 0, 4,   1, 1, 2,   1);
        vecs[12] = mkv(0, n0, 1, 32'hC1,    2'b00, 0,   1, 1, 1, 1, 1, 4,   0, 0, 0,   1);
        vecs[13] = mkv(0, n0, 1, 32'hC2,    2'b00, 0,   1, 1, 1, 2, 2, 4,   0, 0, 0,   1);
        vecs[14] = mkv(0, n0, 1, 32'hC3,    2'b00, 1,   1, 1, 1, 3, 3, 4,   0, 0, 0,   1);
        vecs[15] = mkv(0, n0, 0, 32'h0,     2'b00, 0,   1, 0, 0, 0, 0, 0,   1, 0, 4,   1);
        vecs[16] = mkv(0, n0, 0, 32'h0,     2'b00, 0,   1, 0, 0, 0, 0, 0,   0, 0, 0,   0);

        // Reset state
        #1;
        chk("rst_dready", 32'(dready[0]), 32'd0);
        chk("rst_dvalid", 32'(dvalid[0]), 32'd0);
        chk("rst_derr", 32'(derr[0]), 32'd0);
        chk("rst_rready", 32'(rready[0]), 32'd0);
        chk("rst_wvalid", 32'(wvalid[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) apply_vec(vecs[i], i);

        // Four refills back to back fill the queue, then 16 beats stream gap-free
        starts = '{2'd1, 2'd3, 2'd0, 2'd2};
        ways   = '{4'h1, 4'h2, 4'h4, 4'h8};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            desc_valid_i = 1'b1;
            desc_i       = mkd(1'b1, starts[k], ways[k]);
            r_valid      = 1'b0;
            #1;
            chk("b2b_dready", 32'(dready[0]), 32'd1);
        end
        @(negedge clk);
        desc_i = mkd(1'b0, 2'd0, 4'hF);
        #1;
        chk("b2b_full", 32'(dready[0]), 32'd0);
        nout = 0;
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            desc_valid_i = 1'b0;
            r_valid      = 1'b1;
            r_chan.data  = 32'h100 + 32'(b);
            r_chan.resp  = 2'b00;
            r_chan.last  = ((b % 4) == 3);
            #1;
            eblk = starts[b / 4] + 2'(b % 4);
            chk("b2b_rready", 32'(rready[0]), 32'd1);
            chk("b2b_blk", 32'(way_o[0].blk_offset), 32'(eblk));
            if (dvalid[0]) begin
                if (nout < 4) chk("b2b_order", 32'(desc_o[0].way_ind), 32'(ways[nout]));
                nout++;
            end
        end
        @(negedge clk);
        r_valid = 1'b0;
        #1;
        if (dvalid[0]) begin
            if (nout < 4) chk("b2b_order", 32'(desc_o[0].way_ind), 32'(ways[nout]));
            nout++;
        end
        chk("b2b_nout", 32'(nout), 32'd4);

        // Output register blocked: refill at the head must not take beats
        @(negedge clk);
        desc_ready_i = 1'b0;
        desc_valid_i = 1'b1;
        desc_i       = mkd(1'b0, 2'd0, 4'h1);
        @(negedge clk);
        desc_i = mkd(1'b1, 2'd0, 4'h2);
        @(negedge clk);
        desc_i      = mkd(1'b0, 2'd0, 4'h4);
        r_valid     = 1'b1;
        r_chan.data = 32'h200;
        r_chan.last = 1'b0;
        #1;
        chk("bp_ovalid", 32'(dvalid[0]), 32'd1);
        chk("bp_rready", 32'(rready[0]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            desc_valid_i = 1'b0;
            #1;
            chk("bp_hold_rready", 32'(rready[0]), 32'd0);
            chk("bp_hold_wvalid", 32'(wvalid[0]), 32'd0);
        end
        exp_order = '{4'h1, 4'h2, 4'h4};
        nout  = 0;
        beats = 0;
        for (int c = 0; c < 30 && !(nout == 3 && beats == 4); c++) begin
            @(negedge clk);
            desc_ready_i = 1'b1;
            r_valid      = (beats < 4);
            r_chan.data  = 32'h200 + 32'(beats);
            r_chan.last  = (beats == 3);
            #1;
            if (dvalid[0]) begin
                if (nout < 3) got[nout] = desc_o[0].way_ind;
                nout++;
            end
            if (r_valid && rready[0]) begin
                chk("bp_wdata", way_o[0].data, 32'h200 + 32'(beats));
                chk("bp_blk", 32'(way_o[0].blk_offset), 32'(beats));
                beats++;
            end
        end
        r_valid = 1'b0;
        chk("bp_nout", 32'(nout), 32'd3);
        chk("bp_beats", 32'(beats), 32'd4);
        for (int k = 0; k < 3; k++) chk("bp_order", 32'(got[k]), 32'(exp_order[k]));

        // Reset asserted during the third beat of a burst
        @(negedge clk);
        desc_valid_i = 1'b1;
        desc_i       = mkd(1'b1, 2'd2, 4'h1);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            desc_valid_i = 1'b0;
            r_valid      = 1'b1;
            r_chan.data  = 32'h300 + 32'(b);
            r_chan.last  = 1'b0;
        end
        #1;
        chk("mid_wvalid", 32'(wvalid[0]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_wvalid", 32'(wvalid[0]), 32'd0);
        chk("arst_rready", 32'(rready[0]), 32'd0);
        chk("arst_dready", 32'(dready[0]), 32'd0);
        chk("arst_dvalid", 32'(dvalid[0]), 32'd0);
        chk("arst_derr", 32'(derr[0]), 32'd0);
        chk("arst_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        r_valid = 1'b0;
        #1;
        chk("rel_dready", 32'(dready[0]), 32'd1);
        chk("rel_busy", 32'(busy[0]), 32'd0);
        chk("rel_rready", 32'(rready[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
